// File: rtl/p_r3_dma_if.sv
// Register-3 FIFO read port plus byte-wide memory write port of the parasite DMA engine.
// The master side is the DMA; the slave side is the FIFO and memory it serves.
interface p_r3_dma_if #(
    parameter int ADDR_W = 16
);
    logic              r3_data_available;
    logic              r3_two_bytes_available;
    logic [7:0]        r3_data;
    logic              r3_select;
    logic              r3_rdnw;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack;

    modport master (
        input  r3_data_available, r3_two_bytes_available, r3_data, mem_ack,
        output r3_select, r3_rdnw, mem_req, mem_addr, mem_wdata
    );

    modport slave (
        output r3_data_available, r3_two_bytes_available, r3_data, mem_ack,
        input  r3_select, r3_rdnw, mem_req, mem_addr, mem_wdata
    );
endinterface

// File: rtl/p_r3_dma.sv
// Parasite-side block-transfer engine: drains the host-to-parasite register-3 FIFO
// into parasite memory, one or two bytes per FIFO visit, under a req/ack write handshake.
module p_r3_dma #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              p_phi2,
    input  logic              h_rst_b,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  byte_count,
    input  logic              one_byte_mode,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  remaining,
    p_r3_dma_if.master        bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_RD0, S_RD1, S_WR0, S_WR1, S_GAP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  rem_q;
    logic              one_q;
    logic [7:0]        lat0_q;
    logic [7:0]        lat1_q;
    logic              err_q;
    logic              done_q;
    logic              start_ok;
    logic              start_bad;
    logic              fin;
    logic              ack_wr;

    // Two-byte mode cannot move an odd count, so such a start is refused up front.
    assign start_ok  = start && (byte_count != '0) && (one_byte_mode || !byte_count[0]);
    assign start_bad = start && !start_ok;
    assign ack_wr    = bus.mem_ack && ((state == S_WR0) || (state == S_WR1));

    always_ff @(posedge p_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fin       = 1'b0;
        case (state)
            S_IDLE: if (start_ok) state_nxt = S_WAIT;
            S_WAIT: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    fin       = 1'b1;
                end else if (one_q ? bus.r3_data_available : bus.r3_two_bytes_available) begin
                    state_nxt = S_RD0;
                end
            end
            S_RD0:  state_nxt = one_q ? S_WR0 : S_RD1;
            S_RD1:  state_nxt = S_WR0;
            S_WR0:  if (bus.mem_ack) state_nxt = one_q ? S_GAP : S_WR1;
            S_WR1:  if (bus.mem_ack) state_nxt = S_GAP;
            S_GAP: begin
                // Abort is only honoured here or in WAIT, so latched bytes always reach memory.
                if ((rem_q == '0) || abort) begin
                    state_nxt = S_IDLE;
                    fin       = 1'b1;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge p_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            addr_q <= '0;
            rem_q  <= '0;
            one_q  <= 1'b0;
            lat0_q <= '0;
            lat1_q <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= fin || ((state == S_IDLE) && start_bad);
            if ((state == S_IDLE) && start_ok) begin
                addr_q <= start_addr;
                rem_q  <= byte_count;
                one_q  <= one_byte_mode;
                err_q  <= 1'b0;
            end else if ((state == S_IDLE) && start_bad) begin
                err_q  <= 1'b1;
            end
            if (state == S_RD0) lat0_q <= bus.r3_data;
            if (state == S_RD1) lat1_q <= bus.r3_data;
            if (ack_wr) begin
                addr_q <= addr_q + ADDR_W'(1);
                rem_q  <= rem_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        bus.r3_select = 1'b0;
        bus.r3_rdnw   = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = lat0_q;
        busy          = (state != S_IDLE);
        done          = done_q;
        err           = err_q;
        remaining     = rem_q;
        case (state)
            S_RD0, S_RD1: begin
                bus.r3_select = 1'b1;
                bus.r3_rdnw   = 1'b1;
            end
            S_WR0: bus.mem_req = 1'b1;
            S_WR1: begin
                bus.mem_req   = 1'b1;
                bus.mem_wdata = lat1_q;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/p_r3_dma.md
Name: p_r3_dma

Overview:
- Parasite-side block-transfer engine that drains the host-to-parasite register-3 two-byte FIFO straight into parasite memory.
- Started by parasite firmware with an address and a byte count. Honours one-byte and two-byte FIFO modes.
- Issues FIFO read strobes and byte-wide memory writes under a req/ack handshake, so the parasite CPU is not involved in each byte.

Parameters:
- ADDR_W, 16, memory address width
- CNT_W, 16, transfer byte-count width

Ports:
- p_phi2  in  1  single clock; all state updates on rising edge
- h_rst_b  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; loads start_addr/byte_count when idle
- abort  in  1  level; stops the transfer at the next safe point
- start_addr  in  ADDR_W  first destination address
- byte_count  in  CNT_W  bytes to transfer
- one_byte_mode  in  1  FIFO mode, sampled at start, must be held during transfer
- r3_data_available  in  1  FIFO data-available flag
- r3_two_bytes_available  in  1  FIFO two-bytes flag
- r3_data  in  8  FIFO read data, valid in the strobe cycle
- r3_select  out  1  FIFO data select
- r3_rdnw  out  1  FIFO read strobe qualifier
- mem_req  out  1  memory write request
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  8  write data
- mem_ack  in  1  write accepted at this edge
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky start-error flag; cleared by the next accepted start
- remaining  out  CNT_W  bytes still to write

Behaviour:
- Reset: every output 0; state IDLE; internal address, count and byte latches 0. Reset mid-transfer abandons it; no further strobes or requests are issued.
- Start is accepted only in IDLE. Otherwise it is ignored.
- Start error: byte_count==0, or an odd byte_count with one_byte_mode=0, sets err=1 and pulses done. State stays IDLE and no FIFO read occurs.
- Valid start: latches addr, remaining=byte_count and mode; clears err; busy=1 from the next cycle.
- States: IDLE, WAIT, RD0, RD1, WR0, WR1, GAP.
- WAIT:
  - one-byte mode: go to RD0 when r3_data_available=1.
  - two-byte mode: go to RD0 when r3_two_bytes_available=1.
  - abort=1 in WAIT: go to IDLE, busy=0, done pulse. remaining keeps its value.
- RD0: r3_select=r3_rdnw=1 for exactly this cycle; capture r3_data into byte latch 0.
  - Two-byte mode: next state RD1.
  - Otherwise: next state WR0.
- RD1: one strobe cycle; capture r3_data into byte latch 1; next state WR0. RD0 and RD1 are back-to-back; there is no idle cycle between the two strobes.
- WR0: mem_req=1, mem_addr=addr, mem_wdata=latch 0, all held stable until mem_ack=1.
  - On ack: addr+1, remaining-1.
  - Next state: WR1 if two-byte mode, else GAP.
- WR1: same handshake with latch 1; on ack: addr+1, remaining-1; next state GAP.
- mem_ack outside WR0/WR1 is ignored.
- GAP: one cycle with no strobe, letting the FIFO flags settle.
  - remaining==0: go to IDLE, busy=0, done=1 for one cycle.
  - abort=1: same exit, remaining left non-zero.
  - Otherwise: go to WAIT.
- Abort never interrupts RD0/RD1/WR0/WR1. Bytes already read are always written.
- Address wraps modulo 2^ADDR_W without error.
- At most one strobe per cycle; r3_select and r3_rdnw are never asserted outside RD0/RD1.
- Latency, one-byte mode with a full FIFO and immediate ack: start to first strobe is 2 cycles (IDLE→WAIT→RD0). Per byte is 4 cycles (WAIT, RD0, WR0, GAP).

Test Plan:
- One-byte mode, start_addr=0x1000, byte_count=3; FIFO supplies 0xA1,0xB2,0xC3; mem_ack immediate -> writes 0x1000=A1, 0x1001=B2, 0x1002=C3; exactly 3 strobes; single done pulse; busy=0, remaining=0.
- Two-byte mode, count=4, bytes 0x11,0x22,0x33,0x44, with r3_two_bytes_available held low for 5 cycles before each pair -> no strobe while low; strobes in adjacent cycles per pair; writes in order 11,22,33,44.
- Two-byte mode, count=3 -> err=1, done pulse, no strobes, busy stays 0. A following valid start clears err.
- mem_ack delayed 3 cycles on the second write -> mem_addr and mem_wdata stable throughout; remaining decrements only on the ack edge.
- start_addr=0xFFFF, count=2, one-byte mode -> writes to 0xFFFF then 0x0000.
- abort asserted during WR0 of byte 2 of 5 -> byte 2 is still written; exit from GAP with done; remaining=3; no further strobes. Separately, h_rst_b low during RD1 -> all outputs 0 immediately.
